// File: rtl/div_iter_pkg.sv
// Shared constants and state encoding for the iterative radix-2 restoring divider.
package div_iter_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it does not go negative. Purely combinational.
module div_step
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);
  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_sub;

  assign w_sh  = {i_rem, i_msb};
  assign o_q   = (w_sh >= {1'b0, i_dvs});
  // When the subtract is taken the result is below the divisor, so the low WIDTH bits are exact.
  assign w_sub = w_sh[WIDTH-1:0] - i_dvs;
  assign o_rem = o_q ? w_sub : w_sh[WIDTH-1:0];
endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider: one quotient bit per clock, complete pulses 33 clocks after
// the request edge. Operands are captured in IDLE; cancel aborts from any state.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             complete,
  output logic             busy
);
  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_r;
  logic             r_complete;
  logic             r_busy;

  logic             w_x_neg;
  logic             w_y_neg;
  logic [WIDTH-1:0] w_x_abs;
  logic [WIDTH-1:0] w_y_abs;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_q_bit;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign w_x_neg = div_signed & x[WIDTH-1];
  assign w_y_neg = div_signed & y[WIDTH-1];
  assign w_x_abs = w_x_neg ? -x : x;
  assign w_y_abs = w_y_neg ? -y : y;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_msb (r_dvd[WIDTH-1]),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_bit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_s        <= '0;
      r_r        <= '0;
      r_complete <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      if (cancel) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (div) begin
              r_dvd    <= w_x_abs;
              r_dvs    <= w_y_abs;
              r_sign_q <= w_x_neg ^ w_y_neg;
              r_sign_r <= w_x_neg;
              r_rem    <= '0;
              r_quo    <= '0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_BUSY;
            end
          end
          S_BUSY: begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_DONE;
          end
          S_DONE: begin
            r_s        <= r_sign_q ? -r_quo : r_quo;
            r_r        <= r_sign_r ? -r_rem : r_rem;
            r_complete <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign s        = r_s;
  assign r        = r_r;
  // A flush arriving in the pulse cycle must still hide the result.
  assign complete = r_complete & ~cancel;
  assign busy     = r_busy;
endmodule
